// File: rtl/mem_bus_scheduler_if.sv
// Request/response and memory-bus signal bundle for mem_bus_scheduler.
// master: the scheduler itself (drives readies, responses and the memory bus).
// slave : the requesters and the memory model (drive requests and completions).
interface mem_bus_scheduler_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // Port 0: instruction fetch, read-only
   logic                  p0_req_valid;
   logic [ADDR_WIDTH-1:0] p0_addr;
   logic                  p0_req_ready;
   logic                  p0_rsp_valid;
   logic [DATA_WIDTH-1:0] p0_rdata;

   // Port 1: load/store MMU, read/write
   logic                  p1_req_valid;
   logic [ADDR_WIDTH-1:0] p1_addr;
   logic                  p1_we;
   logic [DATA_WIDTH-1:0] p1_wdata;
   logic                  p1_req_ready;
   logic                  p1_rsp_valid;
   logic [DATA_WIDTH-1:0] p1_rdata;

   // Shared main-memory bus
   logic                  mem_req_valid;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_data_valid;

   modport master (
      input  p0_req_valid, p0_addr,
      output p0_req_ready, p0_rsp_valid, p0_rdata,
      input  p1_req_valid, p1_addr, p1_we, p1_wdata,
      output p1_req_ready, p1_rsp_valid, p1_rdata,
      output mem_req_valid, mem_addr, mem_we, mem_wdata,
      input  mem_rdata, mem_data_valid
   );

   modport slave (
      output p0_req_valid, p0_addr,
      input  p0_req_ready, p0_rsp_valid, p0_rdata,
      output p1_req_valid, p1_addr, p1_we, p1_wdata,
      input  p1_req_ready, p1_rsp_valid, p1_rdata,
      input  mem_req_valid, mem_addr, mem_we, mem_wdata,
      output mem_rdata, mem_data_valid
   );
endinterface

// File: rtl/mem_bus_scheduler.sv
// Shared main-memory bus scheduler between instruction fetch (port 0) and
// the load/store MMU (port 1). One transaction in flight at a time.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; grant a request unless stalled or flushing
// BUSY  | mem_req_valid held; waiting for mem_data_valid or timeout
// RESP  | one-cycle rsp_valid pulse to the owning port
//
// Arbitration is data-first: port 1 wins a tie unless port 0 has been passed
// over STARVE_LIMIT times in a row while waiting.
module mem_bus_scheduler #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                system_flush,
   input  logic                system_stall,
   mem_bus_scheduler_if.master bus,
   output logic                timeout_err
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  owner;        // 0 = port 0, 1 = port 1
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] p0_rdata_q;
   logic [DATA_WIDTH-1:0] p1_rdata_q;
   logic [SW-1:0]         starve_cnt;
   logic [TW-1:0]         to_cnt;

   logic can_grant;
   logic grant_p0;
   logic grant_p1;
   logic flush_p0;
   logic rd_done;

   // Grant selection; reset gating keeps readies low while reset is held
   always_comb begin
      can_grant = (state == S_IDLE) && !system_stall && !system_flush && !reset;
      grant_p0  = can_grant && bus.p0_req_valid &&
                  (!bus.p1_req_valid || (starve_cnt == STARVE_MAX));
      grant_p1  = can_grant && bus.p1_req_valid && !grant_p0;
      // A flush only kills speculative instruction fetches; MMU traffic completes.
      flush_p0  = system_flush && !owner;
      rd_done   = (state == S_BUSY) && bus.mem_data_valid && !flush_p0 && !we_q;
   end

   // Next-state and output decode
   always_comb begin
      state_nxt         = state;
      bus.p0_req_ready  = 1'b0;
      bus.p1_req_ready  = 1'b0;
      bus.p0_rsp_valid  = 1'b0;
      bus.p1_rsp_valid  = 1'b0;
      bus.mem_req_valid = 1'b0;
      bus.mem_addr      = '0;
      bus.mem_we        = 1'b0;
      bus.mem_wdata     = '0;
      timeout_err       = 1'b0;
      case (state)
         S_IDLE: begin
            bus.p0_req_ready = grant_p0;
            bus.p1_req_ready = grant_p1;
            if (grant_p0 || grant_p1) begin
               state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            bus.mem_req_valid = 1'b1;
            bus.mem_addr      = addr_q;
            bus.mem_we        = we_q;
            bus.mem_wdata     = wdata_q;
            // Flush beats a same-cycle completion; completion beats timeout.
            if (flush_p0) begin
               state_nxt = S_IDLE;
            end else if (bus.mem_data_valid) begin
               state_nxt = S_RESP;
            end else if (to_cnt == TO_LAST) begin
               timeout_err = 1'b1;
               state_nxt   = S_IDLE;
            end
         end
         S_RESP: begin
            bus.p0_rsp_valid = !owner && !system_flush;
            bus.p1_rsp_valid = owner;
            state_nxt        = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      bus.p0_rdata = p0_rdata_q;
      bus.p1_rdata = p1_rdata_q;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latch the accepted request; port 0 is always a read
   always_ff @(posedge clk) begin
      if (reset) begin
         owner   <= 1'b0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else if (grant_p0) begin
         owner   <= 1'b0;
         addr_q  <= bus.p0_addr;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else if (grant_p1) begin
         owner   <= 1'b1;
         addr_q  <= bus.p1_addr;
         we_q    <= bus.p1_we;
         wdata_q <= bus.p1_wdata;
      end
   end

   // Starvation guard: count port-1 wins that left port 0 waiting
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (grant_p0) begin
         starve_cnt <= '0;
      end else if (grant_p1 && bus.p0_req_valid && (starve_cnt != STARVE_MAX)) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end

   // Response timeout counter, restarts on every entry into BUSY
   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt <= '0;
      end else if (state == S_BUSY) begin
         to_cnt <= to_cnt + TW'(1);
      end else begin
         to_cnt <= '0;
      end
   end

   // Per-port read data; writes leave the last read value in place
   always_ff @(posedge clk) begin
      if (reset) begin
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
      end else if (rd_done) begin
         if (owner) begin
            p1_rdata_q <= bus.mem_rdata;
         end else begin
            p0_rdata_q <= bus.mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_scheduler.sv
// Bench for mem_bus_scheduler: requester tasks, a latency-programmable memory
// responder, and a scoreboard of expected responses filled at request accept.
module tb_mem_bus_scheduler;

   logic clk = 1'b0;
   logic reset;
   logic system_flush;
   logic system_stall;
   logic timeout_err;

   mem_bus_scheduler_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   mem_bus_scheduler #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .STARVE_LIMIT(4),
      .TIMEOUT     (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .system_flush(system_flush),
      .system_stall(system_stall),
      .bus         (bus),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          port;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   exp_t        exp_q[$];
   int          grant_log[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          grant_cyc = 0;
   int          rise_cyc = 0;
   int          rsp_cyc = 0;
   int          to_cyc = 0;
   int          n_grant = 0;
   int          n_rsp = 0;
   int          n_to = 0;
   logic [31:0] sh0 = '0;
   logic [31:0] sh1 = '0;
   int          mem_lat = 0;     // BUSY cycle on which memory completes; 0 = never
   bit          force_dv = 1'b0; // stray completion strobe, independent of the bus

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return {a[15:0] ^ 16'hC3A5, a[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic send_p0(input logic [31:0] a);
      bit got = 1'b0;
      bus.p0_addr      = a;
      bus.p0_req_valid = 1'b1;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         got = bus.p0_req_ready;
      end
      chk("p0_accept", got, 1);
      @(posedge clk); #1;
      bus.p0_req_valid = 1'b0;
   endtask

   task automatic send_p1(input logic [31:0] a, input bit we, input logic [31:0] wd);
      bit got = 1'b0;
      bus.p1_addr      = a;
      bus.p1_we        = we;
      bus.p1_wdata     = wd;
      bus.p1_req_valid = 1'b1;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         got = bus.p1_req_ready;
      end
      chk("p1_accept", got, 1);
      @(posedge clk); #1;
      bus.p1_req_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = (exp_q.size() == 0) && !bus.mem_req_valid &&
              !bus.p0_rsp_valid && !bus.p1_rsp_valid;
      end
      chk(tag, ok, 1);
      @(posedge clk); #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_p0_ready"}, bus.p0_req_ready, 0);
      chk({tag, "_p1_ready"}, bus.p1_req_ready, 0);
      chk({tag, "_p0_rsp"}, bus.p0_rsp_valid, 0);
      chk({tag, "_p1_rsp"}, bus.p1_rsp_valid, 0);
      chk({tag, "_p0_rdata"}, bus.p0_rdata, 0);
      chk({tag, "_p1_rdata"}, bus.p1_rdata, 0);
      chk({tag, "_mem_req"}, bus.mem_req_valid, 0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 0);
      chk({tag, "_mem_we"}, bus.mem_we, 0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
      chk({tag, "_timeout"}, timeout_err, 0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Memory responder: completes on BUSY cycle mem_lat, plus forced strobes
   initial begin
      int busy_cyc = 0;
      bus.mem_data_valid = 1'b0;
      bus.mem_rdata      = '0;
      forever begin
         @(posedge clk); #2;
         if (bus.mem_req_valid) busy_cyc++;
         else busy_cyc = 0;
         bus.mem_data_valid = force_dv ||
                              (bus.mem_req_valid && mem_lat > 0 && busy_cyc == mem_lat);
         bus.mem_rdata = force_dv ? 32'hBAD0BAD0 : mem_model(bus.mem_addr);
      end
   end

   // Monitor / scoreboard
   initial begin
      bit          prev_mrv = 1'b0;
      exp_t        e;
      logic [31:0] er;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_q.delete();
            sh0      = '0;
            sh1      = '0;
            prev_mrv = 1'b0;
         end else begin
            chk("one_ready", bus.p0_req_ready && bus.p1_req_ready, 0);
            if (bus.p0_req_valid && bus.p0_req_ready) begin
               e.port = 1'b0; e.we = 1'b0; e.addr = bus.p0_addr; e.wdata = '0;
               exp_q.push_back(e);
               grant_log.push_back(0);
               grant_cyc = cyc;
               n_grant++;
            end
            if (bus.p1_req_valid && bus.p1_req_ready) begin
               e.port = 1'b1; e.we = bus.p1_we; e.addr = bus.p1_addr; e.wdata = bus.p1_wdata;
               exp_q.push_back(e);
               grant_log.push_back(1);
               grant_cyc = cyc;
               n_grant++;
            end
            if (bus.mem_req_valid && !prev_mrv) rise_cyc = cyc;
            prev_mrv = bus.mem_req_valid;
            if (bus.mem_req_valid && exp_q.size() > 0) begin
               chk("mem_addr", bus.mem_addr, exp_q[0].addr);
               chk("mem_we", bus.mem_we, exp_q[0].we);
               if (exp_q[0].we) chk("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
               if (system_flush && !exp_q[0].port) void'(exp_q.pop_front());
            end
            if (timeout_err) begin
               n_to++;
               to_cyc = cyc;
               if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (bus.p0_rsp_valid || bus.p1_rsp_valid) begin
               n_rsp++;
               rsp_cyc = cyc;
               chk("rsp_one_port", bus.p0_rsp_valid && bus.p1_rsp_valid, 0);
               chk("rsp_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("rsp_port", bus.p1_rsp_valid, e.port);
                  if (!e.port) begin
                     er  = mem_model(e.addr);
                     sh0 = er;
                     chk("p0_rdata", bus.p0_rdata, er);
                  end else begin
                     if (!e.we) sh1 = mem_model(e.addr);
                     chk("p1_rdata", bus.p1_rdata, sh1);
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Directed sequence
   initial begin
      int n0;
      int g0;
      int exp_order[12];
      int t0;
      bit seen;
      exp_order = '{1, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0};

      reset = 1'b1; system_flush = 1'b0; system_stall = 1'b0;
      bus.p0_req_valid = 1'b0; bus.p0_addr = '0;
      bus.p1_req_valid = 1'b0; bus.p1_addr = '0; bus.p1_we = 1'b0; bus.p1_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("rst");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Port 0 read, memory completes on the 2nd BUSY cycle
      mem_lat = 2;
      send_p0(32'h100);
      drain("t1_drain");
      chk("t1_req_latency", rise_cyc - grant_cyc, 1);
      chk("t1_rsp_latency", rsp_cyc - grant_cyc, 3);
      chk("t1_rdata", bus.p0_rdata, 32'hDEADBEEF);

      // Port 1 read then write; write keeps the previous read data
      mem_lat = 1;
      send_p1(32'h300, 1'b0, '0);
      drain("t2_rd_drain");
      send_p1(32'h200, 1'b1, 32'h12345678);
      drain("t2_wr_drain");
      chk("t2_rdata_hold", bus.p1_rdata, mem_model(32'h300));

      // Both ports continuously valid: starvation guard ordering
      g0 = grant_log.size();
      fork
         for (int i = 0; i < 6; i++) send_p0(32'h1000 + 32'(i * 4));
         for (int i = 0; i < 6; i++) send_p1(32'h2000 + 32'(i * 4), 1'(i % 2), 32'hA000 + 32'(i));
      join
      drain("t3_drain");
      chk("t3_grants", grant_log.size() - g0, 12);
      for (int i = 0; i < 12; i++) begin
         if (g0 + i < grant_log.size()) chk($sformatf("t3_order_%0d", i), grant_log[g0 + i], exp_order[i]);
      end

      // Flush during a port-0 BUSY aborts it; late completion is ignored
      mem_lat = 0;
      n0 = n_rsp;
      send_p0(32'h400);
      system_flush = 1'b1;
      @(posedge clk); #1;
      system_flush = 1'b0;
      @(negedge clk);
      chk("t4_mrv_drop", bus.mem_req_valid, 0);
      @(posedge clk); #1;
      force_dv = 1'b1;
      @(posedge clk); #1;
      force_dv = 1'b0;
      repeat (3) @(negedge clk);
      chk("t4_no_rsp", n_rsp - n0, 0);
      chk("t4_rdata_hold", bus.p0_rdata, sh0);
      chk("t4_exp_dropped", exp_q.size(), 0);
      @(posedge clk); #1;
      mem_lat = 1;
      send_p1(32'h500, 1'b0, '0);
      drain("t4_p1_drain");
      chk("t4_p1_served", n_rsp - n0, 1);

      // Timeout: memory never completes
      mem_lat = 0;
      n0 = n_rsp;
      t0 = n_to;
      send_p1(32'h600, 1'b0, '0);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         seen = (n_to != t0);
      end
      chk("t5_timeout_seen", seen, 1);
      chk("t5_timeout_at", to_cyc - rise_cyc, 7);
      repeat (3) @(negedge clk);
      chk("t5_one_pulse", n_to - t0, 1);
      chk("t5_no_rsp", n_rsp - n0, 0);
      chk("t5_idle", bus.mem_req_valid, 0);
      @(posedge clk); #1;

      // Stall blocks grants; release grants port 1 in that cycle
      mem_lat = 1;
      system_stall = 1'b1;
      g0 = n_grant;
      fork
         send_p0(32'h700);
         send_p1(32'h704, 1'b0, '0);
         begin
            repeat (6) @(negedge clk);
            chk("t6_no_grant", n_grant - g0, 0);
            @(posedge clk); #1;
            system_stall = 1'b0;
            @(negedge clk);
            chk("t6_rel_p1", bus.p1_req_ready, 1);
            chk("t6_rel_p0", bus.p0_req_ready, 0);
         end
      join
      drain("t6_drain");

      // Reset in the middle of BUSY
      mem_lat = 0;
      send_p1(32'h800, 1'b1, 32'hCAFEF00D);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check_zero("rst_mid");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Normal operation after reset
      mem_lat = 3;
      send_p0(32'h900);
      drain("t7_drain");
      chk("t7_rdata", bus.p0_rdata, mem_model(32'h900));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
